countdown_timer: RTL
====================

Name: countdown_timer

Overview:
Loadable down-counter with underflow detection; the count-down counterpart of the team's 4-bit up-counter with overflow flag. Software or an upstream FSM loads a start value. The block decrements on each enabled cycle, flags underflow (sticky and single-cycle pulse), and either stops or auto-reloads. It serves as a watchdog or interval-timer primitive beside the up-counter.

Parameters:
WIDTH, 4, counter width in bits (legal 2..16)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous reset, active-high
enable  input  1  count enable, active-high; decrement when 1 in RUN
load  input  1  one-cycle load strobe, active-high
load_value  input  WIDTH  start/reload value captured on load
auto_reload  input  1  1: reload on underflow and keep running; 0: stop in EXPIRED
clear_underflow  input  1  clears sticky underflow_out
counter_out  output  WIDTH  current count (registered)
underflow_out  output  1  sticky underflow flag (registered)
underflow_pulse  output  1  one-cycle pulse per underflow event (registered)
running  output  1  1 when state is RUN (registered)

Behaviour:
- All outputs registered; effects visible the cycle after the sampling edge. No combinational input-to-output paths.
- Reset has highest priority and overrides everything. On reset: counter_out=0, reload_reg=0, underflow_out=0, underflow_pulse=0, state=IDLE, running=0.
- States: IDLE (after reset, holds count), RUN (counting), EXPIRED (stopped after underflow, holds 0).
- load (any state): counter_out<=load_value, reload_reg<=load_value, state->RUN. Load beats enable in the same cycle: no decrement, no underflow event.
- RUN, enable=1, counter_out!=0: counter_out<=counter_out-1.
- RUN, enable=1, counter_out==0: underflow event.
  - underflow_pulse<=1 for exactly one cycle; underflow_out<=1.
  - If auto_reload=1: counter_out<=reload_reg and stay in RUN.
  - If auto_reload=0: counter_out stays 0 and state->EXPIRED.
  - The counter never wraps to all-ones.
- RUN, enable=0: hold count. underflow_pulse<=0.
- IDLE/EXPIRED: counter held; enable ignored; leave only via load.
- Terminal count is 0, so a load of N gives N+1 enabled cycles to underflow. Load 0 underflows on the first enabled cycle.
- Auto-reload with reload_reg=0 underflows on every enabled cycle.
- clear_underflow=1: underflow_out<=0, unless an underflow event occurs the same cycle, in which case set wins (underflow_out=1).
- auto_reload is sampled only on the underflow cycle; changes mid-count have no other effect.
- underflow_pulse is 0 in every cycle without an event, including load cycles.
- reload_reg is internal and updated only by load or reset.

Optional Feature:
COUNTDOWN_EVENT_COUNT_EN
- Defined: adds output port underflow_count [7:0], an 8-bit saturating count of underflow events.
  - Reset to 0 by reset.
  - Incremented on each underflow_pulse event; holds at 255.
  - Cleared by clear_underflow. If clear and an event coincide, result is 1.
- Undefined: port and logic absent; all other behaviour is identical.

Decomposition:
- Package countdown_pkg:
  - state typedef: IDLE=2'b00, RUN=2'b01, EXPIRED=2'b10 (2'b11 unused; it must recover to IDLE on the next edge)
  - constant COUNTDOWN_DEFAULT_WIDTH=4
  - constant EVENT_COUNT_MAX=8'd255
- One natural sub-module: sat_event_counter (8-bit saturating counter with inc/clear, clear+inc yields 1). Instantiated only under COUNTDOWN_EVENT_COUNT_EN.

Test Plan:
1. Reset mid-count: load 4'd9, enable 3 cycles, assert reset -> next cycle counter_out=0, underflow_out=0, running=0, state IDLE; enable alone then keeps counter_out=0.
2. One-shot: load 4'd3, auto_reload=0, enable held -> counter_out 3,2,1,0; underflow_pulse=1 for one cycle after the 0-cycle; underflow_out=1; running=0; counter_out stays 0 for 10 further cycles.
3. Auto-reload: load 4'd2, auto_reload=1, enable held 9 cycles -> sequence 2,1,0,2,1,0,2,1,0; exactly 2 underflow pulses, 3 cycles apart; running stays 1.
4. Load vs enable and gated enable: in RUN at 4'd5, assert load=1 with load_value=4'd12 and enable=1 -> counter_out=12, no pulse. Then toggle enable 1,0,1 -> 11,11,10.
5. Clear vs set collision: sticky underflow_out=1, auto_reload=1, counter at 0; assert clear_underflow and enable together -> underflow_out remains 1, pulse=1. A lone clear next cycle -> underflow_out=0.
6. With COUNTDOWN_EVENT_COUNT_EN: load 4'd0, auto_reload=1, enable 300 cycles -> underflow_count=255 (saturated). clear_underflow plus an event in the same cycle -> underflow_count=1.

Source files
------------

// File: rtl/countdown_pkg.sv
// Shared types and constants for the countdown timer and its optional event counter.
package countdown_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUN     = 2'b01,
    EXPIRED = 2'b10
  } state_t;

  localparam int         COUNTDOWN_DEFAULT_WIDTH = 4;
  localparam logic [7:0] EVENT_COUNT_MAX         = 8'd255;

endpackage

// File: rtl/countdown_timer_sat_event_counter.sv
// 8-bit saturating event counter with increment and clear; clear plus increment yields 1.
// Only built when COUNTDOWN_EVENT_COUNT_EN is defined, since nothing else uses it.
`ifdef COUNTDOWN_EVENT_COUNT_EN
module sat_event_counter
  import countdown_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       clear,
  output logic [7:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= 8'd0;
    end else if (clear) begin
      count <= inc ? 8'd1 : 8'd0;
    end else if (inc && (count != EVENT_COUNT_MAX)) begin
      count <= count + 8'(1);
    end
  end

endmodule
`endif

// File: rtl/countdown_timer.sv
// Loadable down-counter with sticky/pulsed underflow and optional auto-reload.
// Define COUNTDOWN_EVENT_COUNT_EN to add the saturating underflow_count output.
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int WIDTH = COUNTDOWN_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             auto_reload,
  input  logic             clear_underflow,
  output logic [WIDTH-1:0] counter_out,
  output logic             underflow_out,
  output logic             underflow_pulse,
`ifdef COUNTDOWN_EVENT_COUNT_EN
  output logic [7:0]       underflow_count,
`endif
  output logic             running
);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] reload_reg;
  logic [WIDTH-1:0] count_next;
  logic [WIDTH-1:0] reload_next;
  logic             flag_next;
  logic             underflow_event;

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      counter_out     <= '0;
      reload_reg      <= '0;
      underflow_out   <= 1'b0;
      underflow_pulse <= 1'b0;
      running         <= 1'b0;
    end else begin
      state           <= state_next;
      counter_out     <= count_next;
      reload_reg      <= reload_next;
      underflow_out   <= flag_next;
      underflow_pulse <= underflow_event;
      running         <= (state_next == RUN);
    end
  end

  // Load outranks counting; an underflow only happens on an enabled RUN cycle at zero.
  always_comb begin
    state_next      = state;
    count_next      = counter_out;
    reload_next     = reload_reg;
    underflow_event = 1'b0;

    if (load) begin
      state_next  = RUN;
      count_next  = load_value;
      reload_next = load_value;
    end else begin
      case (state)
        IDLE, EXPIRED: begin
          state_next = state;
        end
        RUN: begin
          if (enable) begin
            if (counter_out != '0) begin
              count_next = counter_out - WIDTH'(1);
            end else begin
              underflow_event = 1'b1;
              if (auto_reload) begin
                count_next = reload_reg;
              end else begin
                state_next = EXPIRED;
              end
            end
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end

    flag_next = underflow_event | (underflow_out & ~clear_underflow);
  end

`ifdef COUNTDOWN_EVENT_COUNT_EN
  sat_event_counter u_event_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (underflow_event),
    .clear (clear_underflow),
    .count (underflow_count)
  );
`endif

endmodule
